alu_rs: RTL and testbench

//  Reservation station feeding the common ALU. Buffers dispatched integer ops until both

---
 rtl/alu_rs_if.sv | 57 +++++
 rtl/alu_rs.sv | 219 +++++++++++++++++++++
 tb/tb_alu_rs.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rs_if.sv
// Bundle between the dispatcher, the two CDBs and the ALU reservation station.
//   master : dispatcher/testbench side. It drives the dispatch and CDB fields and
//            observes full and the issue packet.
//   slave  : the reservation station. It consumes dispatch and CDB traffic and
//            drives full and the alu_* issue packet.
interface alu_rs_if #(
  parameter int ROB_BIT = 4
);
  // dispatch request
  logic               disp_valid;
  logic [2:0]         disp_op;
  logic [6:0]         disp_op_type;
  logic               disp_has_imm;
  logic               disp_op_addition;
  logic [4:0]         disp_imm;
  logic [31:0]        disp_vi;
  logic [31:0]        disp_vj;
  logic [ROB_BIT-1:0] disp_qi;
  logic [ROB_BIT-1:0] disp_qj;
  logic               disp_ri;
  logic               disp_rj;
  logic [ROB_BIT-1:0] disp_rob;
  // common data buses
  logic               cdb_alu_valid;
  logic [ROB_BIT-1:0] cdb_alu_rob;
  logic [31:0]        cdb_alu_val;
  logic               cdb_lsb_valid;
  logic [ROB_BIT-1:0] cdb_lsb_rob;
  logic [31:0]        cdb_lsb_val;
  // status and issue packet
  logic               full;
  logic               alu_valid;
  logic [31:0]        alu_vi;
  logic [31:0]        alu_vj;
  logic [4:0]         alu_imm;
  logic [2:0]         alu_op;
  logic [6:0]         alu_op_type;
  logic               alu_has_imm;
  logic               alu_op_addition;
  logic [ROB_BIT-1:0] alu_rob;

  modport master (
    output disp_valid, disp_op, disp_op_type, disp_has_imm, disp_op_addition, disp_imm,
           disp_vi, disp_vj, disp_qi, disp_qj, disp_ri, disp_rj, disp_rob,
           cdb_alu_valid, cdb_alu_rob, cdb_alu_val, cdb_lsb_valid, cdb_lsb_rob, cdb_lsb_val,
    input  full, alu_valid, alu_vi, alu_vj, alu_imm, alu_op, alu_op_type, alu_has_imm,
           alu_op_addition, alu_rob
  );

  modport slave (
    input  disp_valid, disp_op, disp_op_type, disp_has_imm, disp_op_addition, disp_imm,
           disp_vi, disp_vj, disp_qi, disp_qj, disp_ri, disp_rj, disp_rob,
           cdb_alu_valid, cdb_alu_rob, cdb_alu_val, cdb_lsb_valid, cdb_lsb_rob, cdb_lsb_val,
    output full, alu_valid, alu_vi, alu_vj, alu_imm, alu_op, alu_op_type, alu_has_imm,
           alu_op_addition, alu_rob
  );
endinterface

// File: rtl/alu_rs.sv
// Reservation station in front of the common ALU.
// Buffers dispatched integer ops until both operands are valid, snoops the ALU and
// LSB CDBs for wakeup, and issues at most one ready op per cycle as a registered packet.
// Ports:
//   clk_in   : system clock
//   rst_in   : asynchronous active-low reset
//   rdy_in   : low freezes all state and outputs
//   clear_in : synchronous flush (mispredict), drops every entry and the issue packet
//   bus      : alu_rs_if slave (dispatch, CDBs, full, alu_* issue packet)
module alu_rs #(
  parameter int RS_BIT  = 3,
  parameter int ROB_BIT = 4
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  input  logic     clear_in,
  alu_rs_if.slave  bus
);
  localparam int RS_SIZE = 1 << RS_BIT;

  // per-entry state
  logic [RS_SIZE-1:0] busy_r;
  logic [RS_SIZE-1:0] ri_r;
  logic [RS_SIZE-1:0] rj_r;
  logic [RS_SIZE-1:0] has_imm_r;
  logic [RS_SIZE-1:0] op_add_r;
  logic [31:0]        vi_r      [RS_SIZE];
  logic [31:0]        vj_r      [RS_SIZE];
  logic [ROB_BIT-1:0] qi_r      [RS_SIZE];
  logic [ROB_BIT-1:0] qj_r      [RS_SIZE];
  logic [2:0]         op_r      [RS_SIZE];
  logic [6:0]         op_type_r [RS_SIZE];
  logic [4:0]         imm_r     [RS_SIZE];
  logic [ROB_BIT-1:0] rob_r     [RS_SIZE];

  // issue packet registers
  logic               alu_valid_r;
  logic [31:0]        alu_vi_r;
  logic [31:0]        alu_vj_r;
  logic [4:0]         alu_imm_r;
  logic [2:0]         alu_op_r;
  logic [6:0]         alu_op_type_r;
  logic               alu_has_imm_r;
  logic               alu_op_add_r;
  logic [ROB_BIT-1:0] alu_rob_r;

  // selection / bypass
  logic [RS_SIZE-1:0] ready_vec_s;
  logic [RS_BIT-1:0]  free_idx_s;
  logic               has_free_s;
  logic [RS_BIT-1:0]  ready_idx_s;
  logic               has_ready_s;
  logic               alu_hit_i_s;
  logic               lsb_hit_i_s;
  logic               alu_hit_j_s;
  logic               lsb_hit_j_s;
  logic               disp_ri_s;
  logic               disp_rj_s;
  logic [31:0]        disp_vi_s;
  logic [31:0]        disp_vj_s;
  logic               disp_fire_s;

  // Select only from registered ri/rj, so an op woken or dispatched this cycle waits one edge.
  assign ready_vec_s = busy_r & ri_r & rj_r;

  // Lowest-index free entry and lowest-index ready entry; scanning downwards lets the
  // lowest index overwrite any higher candidate.
  always_comb begin
    free_idx_s  = '0;
    has_free_s  = 1'b0;
    ready_idx_s = '0;
    has_ready_s = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      free_idx_s  = busy_r[i]      ? free_idx_s  : RS_BIT'(i);
      has_free_s  = has_free_s | ~busy_r[i];
      ready_idx_s = ready_vec_s[i] ? RS_BIT'(i)  : ready_idx_s;
      has_ready_s = has_ready_s | ready_vec_s[i];
    end
  end

  // Dispatch-time bypass from the CDBs; the ALU CDB takes precedence when both match.
  always_comb begin
    alu_hit_i_s = bus.cdb_alu_valid && (bus.cdb_alu_rob == bus.disp_qi);
    lsb_hit_i_s = bus.cdb_lsb_valid && (bus.cdb_lsb_rob == bus.disp_qi);
    alu_hit_j_s = bus.cdb_alu_valid && (bus.cdb_alu_rob == bus.disp_qj);
    lsb_hit_j_s = bus.cdb_lsb_valid && (bus.cdb_lsb_rob == bus.disp_qj);
    disp_ri_s   = bus.disp_ri | alu_hit_i_s | lsb_hit_i_s;
    disp_rj_s   = bus.disp_rj | alu_hit_j_s | lsb_hit_j_s;
    if (bus.disp_ri) begin
      disp_vi_s = bus.disp_vi;
    end else if (alu_hit_i_s) begin
      disp_vi_s = bus.cdb_alu_val;
    end else if (lsb_hit_i_s) begin
      disp_vi_s = bus.cdb_lsb_val;
    end else begin
      disp_vi_s = bus.disp_vi;
    end
    if (bus.disp_rj) begin
      disp_vj_s = bus.disp_vj;
    end else if (alu_hit_j_s) begin
      disp_vj_s = bus.cdb_alu_val;
    end else if (lsb_hit_j_s) begin
      disp_vj_s = bus.cdb_lsb_val;
    end else begin
      disp_vj_s = bus.disp_vj;
    end
  end

  // A dispatch while full is ignored.
  assign disp_fire_s = bus.disp_valid & has_free_s;

  // Entry storage: issue frees, CDB wakeup, dispatch write (never the issuing entry).
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_r    <= '0;
      ri_r      <= '0;
      rj_r      <= '0;
      has_imm_r <= '0;
      op_add_r  <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        vi_r[i]      <= 32'd0;
        vj_r[i]      <= 32'd0;
        qi_r[i]      <= '0;
        qj_r[i]      <= '0;
        op_r[i]      <= 3'd0;
        op_type_r[i] <= 7'd0;
        imm_r[i]     <= 5'd0;
        rob_r[i]     <= '0;
      end
    end else if (!rdy_in) begin
      busy_r <= busy_r;
    end else if (clear_in) begin
      busy_r <= '0;
    end else begin
      if (has_ready_s) begin
        busy_r[ready_idx_s] <= 1'b0;
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_r[i] && !ri_r[i]) begin
          if (bus.cdb_alu_valid && (qi_r[i] == bus.cdb_alu_rob)) begin
            vi_r[i] <= bus.cdb_alu_val;
            ri_r[i] <= 1'b1;
          end else if (bus.cdb_lsb_valid && (qi_r[i] == bus.cdb_lsb_rob)) begin
            vi_r[i] <= bus.cdb_lsb_val;
            ri_r[i] <= 1'b1;
          end
        end
        if (busy_r[i] && !rj_r[i]) begin
          if (bus.cdb_alu_valid && (qj_r[i] == bus.cdb_alu_rob)) begin
            vj_r[i] <= bus.cdb_alu_val;
            rj_r[i] <= 1'b1;
          end else if (bus.cdb_lsb_valid && (qj_r[i] == bus.cdb_lsb_rob)) begin
            vj_r[i] <= bus.cdb_lsb_val;
            rj_r[i] <= 1'b1;
          end
        end
      end
      if (disp_fire_s) begin
        busy_r[free_idx_s]    <= 1'b1;
        ri_r[free_idx_s]      <= disp_ri_s;
        rj_r[free_idx_s]      <= disp_rj_s;
        vi_r[free_idx_s]      <= disp_vi_s;
        vj_r[free_idx_s]      <= disp_vj_s;
        qi_r[free_idx_s]      <= bus.disp_qi;
        qj_r[free_idx_s]      <= bus.disp_qj;
        op_r[free_idx_s]      <= bus.disp_op;
        op_type_r[free_idx_s] <= bus.disp_op_type;
        has_imm_r[free_idx_s] <= bus.disp_has_imm;
        op_add_r[free_idx_s]  <= bus.disp_op_addition;
        imm_r[free_idx_s]     <= bus.disp_imm;
        rob_r[free_idx_s]     <= bus.disp_rob;
      end
    end
  end

  // Issue packet register; data is held when nothing issues.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      alu_valid_r   <= 1'b0;
      alu_vi_r      <= 32'd0;
      alu_vj_r      <= 32'd0;
      alu_imm_r     <= 5'd0;
      alu_op_r      <= 3'd0;
      alu_op_type_r <= 7'd0;
      alu_has_imm_r <= 1'b0;
      alu_op_add_r  <= 1'b0;
      alu_rob_r     <= '0;
    end else if (!rdy_in) begin
      alu_valid_r <= alu_valid_r;
    end else if (clear_in) begin
      alu_valid_r <= 1'b0;
    end else if (has_ready_s) begin
      alu_valid_r   <= 1'b1;
      alu_vi_r      <= vi_r[ready_idx_s];
      alu_vj_r      <= vj_r[ready_idx_s];
      alu_imm_r     <= imm_r[ready_idx_s];
      alu_op_r      <= op_r[ready_idx_s];
      alu_op_type_r <= op_type_r[ready_idx_s];
      alu_has_imm_r <= has_imm_r[ready_idx_s];
      alu_op_add_r  <= op_add_r[ready_idx_s];
      alu_rob_r     <= rob_r[ready_idx_s];
    end else begin
      alu_valid_r <= 1'b0;
    end
  end

  // full follows the busy bits only, so an entry issuing this cycle still counts as used.
  assign bus.full            = ~has_free_s;
  assign bus.alu_valid       = alu_valid_r;
  assign bus.alu_vi          = alu_vi_r;
  assign bus.alu_vj          = alu_vj_r;
  assign bus.alu_imm         = alu_imm_r;
  assign bus.alu_op          = alu_op_r;
  assign bus.alu_op_type     = alu_op_type_r;
  assign bus.alu_has_imm     = alu_has_imm_r;
  assign bus.alu_op_addition = alu_op_add_r;
  assign bus.alu_rob         = alu_rob_r;
endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs.
module tb_alu_rs;
  logic clk_in;
  logic rst_in;
  logic rdy_in;
  logic clear_in;
  int   n_asserts;
  int   n_fail;

  alu_rs_if #(.ROB_BIT(4)) bus ();

  alu_rs #(.RS_BIT(3), .ROB_BIT(4)) dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rdy_in  (rdy_in),
    .clear_in(clear_in),
    .bus     (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic disp(input logic [6:0] ot, input logic [2:0] op, input logic hi,
                      input logic add, input logic [4:0] imm,
                      input logic [31:0] vi, input logic [31:0] vj,
                      input logic [3:0] qi, input logic [3:0] qj,
                      input logic ri, input logic rj, input logic [3:0] rob);
    bus.disp_valid       = 1'b1;
    bus.disp_op_type     = ot;
    bus.disp_op          = op;
    bus.disp_has_imm     = hi;
    bus.disp_op_addition = add;
    bus.disp_imm         = imm;
    bus.disp_vi          = vi;
    bus.disp_vj          = vj;
    bus.disp_qi          = qi;
    bus.disp_qj          = qj;
    bus.disp_ri          = ri;
    bus.disp_rj          = rj;
    bus.disp_rob         = rob;
  endtask

  task automatic cdb_off();
    bus.cdb_alu_valid = 1'b0;
    bus.cdb_lsb_valid = 1'b0;
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    rst_in    = 1'b0;
    rdy_in    = 1'b1;
    clear_in  = 1'b0;
    disp(7'd0, 3'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
    bus.disp_valid  = 1'b0;
    bus.cdb_alu_rob = 4'd0;
    bus.cdb_alu_val = 32'd0;
    bus.cdb_lsb_rob = 4'd0;
    bus.cdb_lsb_val = 32'd0;
    cdb_off();
    tick();
    tick();
    chk("reset_valid", {31'd0, bus.alu_valid}, 32'd0);
    chk("reset_full", {31'd0, bus.full}, 32'd0);
    chk("reset_vi", bus.alu_vi, 32'd0);
    chk("reset_rob", {28'd0, bus.alu_rob}, 32'd0);
    rst_in = 1'b1;
    tick();

    // ADDI ready at dispatch: one idle edge, then issue
    disp(7'b0010011, 3'd0, 1'b1, 1'b0, 5'd3, 32'd5, 32'd0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd2);
    tick();
    bus.disp_valid = 1'b0;
    chk("addi_no_bypass", {31'd0, bus.alu_valid}, 32'd0);
    tick();
    chk("addi_valid", {31'd0, bus.alu_valid}, 32'd1);
    chk("addi_vi", bus.alu_vi, 32'd5);
    chk("addi_imm", {27'd0, bus.alu_imm}, 32'd3);
    chk("addi_rob", {28'd0, bus.alu_rob}, 32'd2);
    chk("addi_has_imm", {31'd0, bus.alu_has_imm}, 32'd1);
    chk("addi_op_type", {25'd0, bus.alu_op_type}, 32'h13);
    tick();
    chk("addi_done", {31'd0, bus.alu_valid}, 32'd0);
    chk("addi_hold_vi", bus.alu_vi, 32'd5);

    // ADD waiting on tag 7, woken by the LSB CDB
    disp(7'b0110011, 3'd0, 1'b0, 1'b1, 5'd0, 32'd1, 32'd0, 4'd0, 4'd7, 1'b1, 1'b0, 4'd3);
    tick();
    bus.disp_valid = 1'b0;
    tick();
    chk("add_waiting", {31'd0, bus.alu_valid}, 32'd0);
    bus.cdb_lsb_valid = 1'b1;
    bus.cdb_lsb_rob   = 4'd7;
    bus.cdb_lsb_val   = 32'h10;
    tick();
    cdb_off();
    chk("add_woken_not_yet", {31'd0, bus.alu_valid}, 32'd0);
    tick();
    chk("add_valid", {31'd0, bus.alu_valid}, 32'd1);
    chk("add_vj", bus.alu_vj, 32'h10);
    chk("add_vi", bus.alu_vi, 32'd1);
    chk("add_rob", {28'd0, bus.alu_rob}, 32'd3);
    chk("add_sub_sel", {31'd0, bus.alu_op_addition}, 32'd1);

    // dispatch-cycle bypass from the ALU CDB
    disp(7'b0110011, 3'd4, 1'b0, 1'b0, 5'd0, 32'hdead, 32'd2, 4'd4, 4'd0, 1'b0, 1'b1, 4'd5);
    bus.cdb_alu_valid = 1'b1;
    bus.cdb_alu_rob   = 4'd4;
    bus.cdb_alu_val   = 32'd9;
    tick();
    bus.disp_valid = 1'b0;
    cdb_off();
    chk("byp_idle", {31'd0, bus.alu_valid}, 32'd0);
    tick();
    chk("byp_valid", {31'd0, bus.alu_valid}, 32'd1);
    chk("byp_vi", bus.alu_vi, 32'd9);
    chk("byp_vj", bus.alu_vj, 32'd2);
    chk("byp_op", {29'd0, bus.alu_op}, 32'd4);
    chk("byp_rob", {28'd0, bus.alu_rob}, 32'd5);
    tick();

    // fill all 8 entries, each waiting on tag i
    for (int i = 0; i < 8; i++) begin
      disp(7'b0110011, 3'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 4'(i), 4'd0, 1'b0, 1'b1, 4'(8 + i));
      tick();
      if (i == 6) chk("fill_7_not_full", {31'd0, bus.full}, 32'd0);
    end
    chk("fill_full", {31'd0, bus.full}, 32'd1);
    disp(7'b0010011, 3'd0, 1'b1, 1'b0, 5'd1, 32'd1, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd15);
    tick();
    bus.disp_valid = 1'b0;
    chk("full_ignore_full", {31'd0, bus.full}, 32'd1);
    chk("full_ignore_v0", {31'd0, bus.alu_valid}, 32'd0);
    tick();
    chk("full_ignore_v1", {31'd0, bus.alu_valid}, 32'd0);
    bus.cdb_alu_valid = 1'b1;
    bus.cdb_alu_rob   = 4'd3;
    bus.cdb_alu_val   = 32'h33;
    tick();
    cdb_off();
    chk("wake3_full", {31'd0, bus.full}, 32'd1);
    chk("wake3_idle", {31'd0, bus.alu_valid}, 32'd0);
    tick();
    chk("wake3_valid", {31'd0, bus.alu_valid}, 32'd1);
    chk("wake3_rob", {28'd0, bus.alu_rob}, 32'd11);
    chk("wake3_vi", bus.alu_vi, 32'h33);
    chk("wake3_not_full", {31'd0, bus.full}, 32'd0);
    disp(7'b0010011, 3'd0, 1'b1, 1'b0, 5'd2, 32'h77, 32'd0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd14);
    tick();
    bus.disp_valid = 1'b0;
    chk("refill_full", {31'd0, bus.full}, 32'd1);
    chk("refill_idle", {31'd0, bus.alu_valid}, 32'd0);
    tick();
    chk("refill_valid", {31'd0, bus.alu_valid}, 32'd1);
    chk("refill_rob", {28'd0, bus.alu_rob}, 32'd14);
    chk("refill_vi", bus.alu_vi, 32'h77);

    // wake entries 1 and 5, then flush before either issues
    bus.cdb_alu_valid = 1'b1;
    bus.cdb_alu_rob   = 4'd1;
    bus.cdb_alu_val   = 32'h11;
    bus.cdb_lsb_valid = 1'b1;
    bus.cdb_lsb_rob   = 4'd5;
    bus.cdb_lsb_val   = 32'h55;
    tick();
    cdb_off();
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    chk("clear_valid", {31'd0, bus.alu_valid}, 32'd0);
    chk("clear_full", {31'd0, bus.full}, 32'd0);
    tick();
    chk("clear_no_issue", {31'd0, bus.alu_valid}, 32'd0);

    // rdy_in low while an issue packet is out holds everything
    disp(7'b0010011, 3'd1, 1'b1, 1'b0, 5'd4, 32'ha1, 32'd0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd1);
    tick();
    disp(7'b0010011, 3'd2, 1'b1, 1'b0, 5'd6, 32'hb2, 32'd0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd2);
    tick();
    bus.disp_valid = 1'b0;
    chk("rdy_a_valid", {31'd0, bus.alu_valid}, 32'd1);
    chk("rdy_a_rob", {28'd0, bus.alu_rob}, 32'd1);
    rdy_in = 1'b0;
    tick();
    tick();
    chk("rdy_hold_valid", {31'd0, bus.alu_valid}, 32'd1);
    chk("rdy_hold_rob", {28'd0, bus.alu_rob}, 32'd1);
    chk("rdy_hold_vi", bus.alu_vi, 32'ha1);
    rdy_in = 1'b1;
    tick();
    chk("rdy_b_rob", {28'd0, bus.alu_rob}, 32'd2);
    chk("rdy_b_vi", bus.alu_vi, 32'hb2);
    chk("rdy_b_imm", {27'd0, bus.alu_imm}, 32'd6);
    tick();
    chk("rdy_b_done", {31'd0, bus.alu_valid}, 32'd0);

    // asynchronous reset mid-run with 3 waiting entries and a packet out
    for (int i = 0; i < 3; i++) begin
      disp(7'b0110011, 3'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 4'd9, 4'd0, 1'b0, 1'b1, 4'(i));
      tick();
    end
    disp(7'b0010011, 3'd0, 1'b1, 1'b0, 5'd0, 32'h66, 32'd0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd6);
    tick();
    bus.disp_valid = 1'b0;
    tick();
    chk("pre_rst_valid", {31'd0, bus.alu_valid}, 32'd1);
    #1;
    rst_in = 1'b0;
    #1;
    chk("rst_valid", {31'd0, bus.alu_valid}, 32'd0);
    chk("rst_full", {31'd0, bus.full}, 32'd0);
    chk("rst_vi", bus.alu_vi, 32'd0);
    #1;
    rst_in = 1'b1;
    bus.cdb_alu_valid = 1'b1;
    bus.cdb_alu_rob   = 4'd9;
    bus.cdb_alu_val   = 32'h99;
    tick();
    cdb_off();
    tick();
    chk("rst_no_issue0", {31'd0, bus.alu_valid}, 32'd0);
    tick();
    chk("rst_no_issue1", {31'd0, bus.alu_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
